spectrum_band_packer: RTL

Producer end of the packed spectrum interface. Consumes the per-bin FFT magnitude stream, sums bins into 8 contiguous frequency bands, scales and saturates each band to 12 bits, and publishes one 96-bit `spectrum_data_packed` word with a single-cycle `spectrum_valid` per frame. It sits between the FFT magnitude stage and the spectrum display and drives that interface directly.

---
 rtl/spectrum_pkg.sv | 18 +
 rtl/band_scale_sat.sv | 20 ++
 rtl/spectrum_band_packer.sv | 110 +++++++++++
 3 files changed

// File: rtl/spectrum_pkg.sv
// rtl/spectrum_pkg.sv - shared band constants, packer state encoding and packed-field offset helper
package spectrum_pkg;

  localparam int NUM_BANDS = 8;
  localparam int BAND_W    = 12;
  localparam int BAND_MAX  = 4095;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    PUBLISH = 2'd1,
    DISCARD = 2'd2
  } state_e;

  function automatic int band_lsb(input int k);
    return k * BAND_W;
  endfunction

endpackage

// File: rtl/band_scale_sat.sv
// rtl/band_scale_sat.sv - combinational right shift and saturation of one band sum to a 12-bit field
module band_scale_sat
  import spectrum_pkg::*;
#(
  parameter int ACC_W       = 20,
  parameter int SCALE_SHIFT = 4
) (
  input  logic [ACC_W-1:0]  acc_i,
  output logic [BAND_W-1:0] field_o
);

  localparam int EXT_W = ACC_W + BAND_W;

  // Zero-extended first so narrow accumulators still compare correctly against BAND_MAX.
  logic [EXT_W-1:0] scaled;

  assign scaled  = {{BAND_W{1'b0}}, acc_i} >> SCALE_SHIFT;
  assign field_o = (scaled > EXT_W'(BAND_MAX)) ? BAND_W'(BAND_MAX) : scaled[BAND_W-1:0];

endmodule

// File: rtl/spectrum_band_packer.sv
// rtl/spectrum_band_packer.sv - sums FFT bins into 8 bands and publishes a 96-bit packed word per frame; SPECTRUM_PEAK_HOLD_EN adds decaying peak hold
module spectrum_band_packer
  import spectrum_pkg::*;
#(
  parameter int N_BINS      = 128,
  parameter int MAG_W       = 16,
  parameter int SCALE_SHIFT = 4,
  parameter int DECAY       = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [MAG_W-1:0]            mag_data,
  input  logic                        mag_valid,
  input  logic                        mag_last,
  output logic                        mag_ready,
  output logic [NUM_BANDS*BAND_W-1:0] spectrum_data_packed,
  output logic                        spectrum_valid
);

  localparam int BPB   = N_BINS / NUM_BANDS;
  localparam int BPB_W = $clog2(BPB);
  localparam int CNT_W = $clog2(N_BINS);
  localparam int ACC_W = MAG_W + BPB_W;

  state_e                        state_q;
  logic [CNT_W-1:0]              bin_cnt_q;
  logic [ACC_W-1:0]              acc_q [NUM_BANDS];
  logic [NUM_BANDS*BAND_W-1:0]   data_q;
  logic                          valid_q;

  logic [BAND_W-1:0]             sat_d   [NUM_BANDS];
  logic [BAND_W-1:0]             field_d [NUM_BANDS];
  logic [NUM_BANDS*BAND_W-1:0]   data_d;
  logic                          accept;
  logic [2:0]                    band_sel;

  assign mag_ready            = (state_q != PUBLISH);
  assign accept               = mag_valid && mag_ready;
  assign band_sel             = bin_cnt_q[CNT_W-1 -: 3];
  assign spectrum_data_packed = data_q;
  assign spectrum_valid       = valid_q;

  // Only legal configurations elaborate the band datapath.
  if (N_BINS >= NUM_BANDS && DECAY >= 0) begin : g_bands
    for (genvar g = 0; g < NUM_BANDS; g++) begin : g_band
      band_scale_sat #(
        .ACC_W      (ACC_W),
        .SCALE_SHIFT(SCALE_SHIFT)
      ) u_scale (
        .acc_i  (acc_q[g]),
        .field_o(sat_d[g])
      );
`ifdef SPECTRUM_PEAK_HOLD_EN
      // The published field doubles as the hold register.
      logic [BAND_W-1:0] hold;
      logic [BAND_W-1:0] decayed;
      assign hold       = data_q[band_lsb(g) +: BAND_W];
      assign decayed    = (hold >= BAND_W'(DECAY)) ? hold - BAND_W'(DECAY) : '0;
      assign field_d[g] = (sat_d[g] > decayed) ? sat_d[g] : decayed;
`else
      assign field_d[g] = sat_d[g];
`endif
    end
  end

  always_comb begin
    data_d = '0;
    for (int k = 0; k < NUM_BANDS; k++) begin
      data_d[band_lsb(k) +: BAND_W] = field_d[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACCUM;
      bin_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      for (int k = 0; k < NUM_BANDS; k++) acc_q[k] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        ACCUM: begin
          if (accept) begin
            acc_q[band_sel] <= acc_q[band_sel] + ACC_W'(mag_data);
            if (mag_last) begin
              state_q <= PUBLISH;
            end else if (bin_cnt_q == CNT_W'(N_BINS - 1)) begin
              state_q <= DISCARD;
            end else begin
              bin_cnt_q <= bin_cnt_q + CNT_W'(1);
            end
          end
        end
        DISCARD: begin
          if (accept && mag_last) state_q <= PUBLISH;
        end
        PUBLISH: begin
          data_q    <= data_d;
          valid_q   <= 1'b1;
          bin_cnt_q <= '0;
          for (int k = 0; k < NUM_BANDS; k++) acc_q[k] <= '0;
          state_q   <= ACCUM;
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

endmodule
